// File: rtl/reg_file.sv
// General-purpose register file with condition codes.
// Holds NREGS registers plus a one-hot {n,z,p} flag register. Reads are
// combinational with no write-to-read bypass. Writes and flag loads happen
// on the rising clock edge.
module reg_file #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       dr,
  input  logic [2:0]       sr1,
  input  logic [2:0]       sr2,
  input  logic [4:0]       imm5,
  input  logic             sr2mux_sel,
  input  logic [WIDTH-1:0] bus,
  input  logic             ld_reg,
  input  logic             ld_cc,
  output logic [WIDTH-1:0] sr1_out,
  output logic [WIDTH-1:0] sr2mux_out,
  output logic             n,
  output logic             z,
  output logic             p
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [2:0]       nzp_q;
  logic [2:0]       nzp_d;
  logic [WIDTH-1:0] imm_sext;

  // Next-state for the register array: only dr changes, and only when ld_reg is set.
  always_comb begin
    regs_d = regs_q;
    if (ld_reg) begin
      regs_d[dr] = bus;
    end
  end

  // Next-state for the flags: classify the bus value as negative, zero or positive.
  always_comb begin
    nzp_d = nzp_q;
    if (ld_cc) begin
      if (bus[WIDTH-1]) begin
        nzp_d = 3'b100;
      end else if (bus == '0) begin
        nzp_d = 3'b010;
      end else begin
        nzp_d = 3'b001;
      end
    end
  end

  // State update; reset is asynchronous and discards any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
      nzp_q  <= 3'b010;
    end else begin
      regs_q <= regs_d;
      nzp_q  <= nzp_d;
    end
  end

  // Operand outputs: direct reads of the current register contents.
  assign imm_sext   = {{(WIDTH - 5){imm5[4]}}, imm5};
  assign sr1_out    = regs_q[sr1];
  assign sr2mux_out = sr2mux_sel ? imm_sext : regs_q[sr2];

  assign n = nzp_q[2];
  assign z = nzp_q[1];
  assign p = nzp_q[0];

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed steps followed by randomized traffic checked
// against a simple array/flag model.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [2:0]  dr;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [4:0]  imm5;
  logic        sr2mux_sel;
  logic [15:0] bus;
  logic        ld_reg;
  logic        ld_cc;
  logic [15:0] sr1_out;
  logic [15:0] sr2mux_out;
  logic        n;
  logic        z;
  logic        p;

  int vectors;
  int miscompares;

  // Reference state
  logic [15:0] m_regs [8];
  logic [2:0]  m_nzp;

  reg_file #(
    .WIDTH(16),
    .NREGS(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dr         (dr),
    .sr1        (sr1),
    .sr2        (sr2),
    .imm5       (imm5),
    .sr2mux_sel (sr2mux_sel),
    .bus        (bus),
    .ld_reg     (ld_reg),
    .ld_cc      (ld_cc),
    .sr1_out    (sr1_out),
    .sr2mux_out (sr2mux_out),
    .n          (n),
    .z          (z),
    .p          (p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sext5(input logic [4:0] v);
    int s;
    s = (v >= 5'd16) ? int'(v) - 32 : int'(v);
    return 16'(s);
  endfunction

  function automatic logic [2:0] classify(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_nzp = 3'b010;
  endtask

  // Apply one rising edge to the model and DUT, then settle just past it.
  task automatic clk_edge();
    @(posedge clk);
    if (rst_n) begin
      if (ld_reg) m_regs[dr] = bus;
      if (ld_cc)  m_nzp = classify(bus);
    end
    #1;
  endtask

  task automatic chk_flags(input string tag);
    chk(tag, {13'd0, n, z, p}, {13'd0, m_nzp});
    chk({tag, "_onehot"}, 16'($countones({n, z, p})), 16'd1);
  endtask

  // Read every register through both read ports; loads are disabled meanwhile.
  task automatic chk_all(input string tag);
    ld_reg = 1'b0;
    ld_cc  = 1'b0;
    sr2mux_sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i);
      sr2 = 3'(i);
      #1;
      chk($sformatf("%s_sr1_r%0d", tag, i), sr1_out, m_regs[i]);
      chk($sformatf("%s_sr2_r%0d", tag, i), sr2mux_out, m_regs[i]);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b1;
    dr = '0; sr1 = '0; sr2 = '0; imm5 = '0; sr2mux_sel = 1'b0;
    bus = '0; ld_reg = 1'b0; ld_cc = 1'b0;
    model_reset();

    // Reset with loads pending: must be all zero, flags 010.
    #2;
    ld_reg = 1'b1; ld_cc = 1'b1; bus = 16'h8888; dr = 3'd4;
    rst_n = 1'b0;
    #1;
    chk_flags("reset_nzp");
    @(posedge clk); #1;
    chk_all("reset");
    chk_flags("reset_nzp2");

    // Release between edges; nothing loads until the next edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;

    // Write R3, read R3 and R2.
    dr = 3'd3; bus = 16'h1234; ld_reg = 1'b1; ld_cc = 1'b0;
    clk_edge();
    ld_reg = 1'b0;
    sr1 = 3'd3; #1;
    chk("wr_r3", sr1_out, 16'h1234);
    sr1 = 3'd2; #1;
    chk("rd_r2", sr1_out, 16'h0000);

    // Same-cycle write/read of R5: old value until the edge.
    clk_edge();
    dr = 3'd5; sr1 = 3'd5; sr2 = 3'd5; sr2mux_sel = 1'b0;
    bus = 16'hBEEF; ld_reg = 1'b1;
    #1;
    chk("nobypass_sr1", sr1_out, m_regs[5]);
    chk("nobypass_sr2", sr2mux_out, m_regs[5]);
    clk_edge();
    ld_reg = 1'b0;
    chk("after_edge_sr1", sr1_out, 16'hBEEF);
    chk("after_edge_sr2", sr2mux_out, 16'hBEEF);

    // Immediate path.
    sr2mux_sel = 1'b1;
    imm5 = 5'b10000; #1;
    chk("imm_neg16", sr2mux_out, 16'hFFF0);
    imm5 = 5'b01111; #1;
    chk("imm_pos15", sr2mux_out, 16'h000F);
    imm5 = 5'b11111; #1;
    chk("imm_neg1", sr2mux_out, 16'hFFFF);
    sr2mux_sel = 1'b0;

    // Condition codes.
    ld_cc = 1'b1; bus = 16'h8000; clk_edge();
    chk("cc_neg", {13'd0, n, z, p}, 16'h0004);
    bus = 16'h0000; clk_edge();
    chk("cc_zero", {13'd0, n, z, p}, 16'h0002);
    bus = 16'h0001; clk_edge();
    chk("cc_pos", {13'd0, n, z, p}, 16'h0001);
    ld_cc = 1'b0; bus = 16'h8000; clk_edge();
    chk("cc_hold", {13'd0, n, z, p}, 16'h0001);

    // Both loads from one bus value; R0 and R7 writable.
    dr = 3'd0; bus = 16'hF00D; ld_reg = 1'b1; ld_cc = 1'b1; clk_edge();
    ld_cc = 1'b0;
    dr = 3'd7; bus = 16'h7FFF; clk_edge();
    chk_all("dual");
    chk_flags("dual_nzp");

    // Randomized traffic against the model.
    for (int it = 0; it < 300; it++) begin
      dr = 3'($urandom); sr1 = 3'($urandom); sr2 = 3'($urandom);
      imm5 = 5'($urandom); sr2mux_sel = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       bus = 16'h0000;
        1:       bus = 16'h8000 | 16'($urandom);
        default: bus = 16'($urandom);
      endcase
      ld_reg = 1'($urandom); ld_cc = 1'($urandom);
      #1;
      chk("rnd_sr1", sr1_out, m_regs[sr1]);
      chk("rnd_sr2mux", sr2mux_out, sr2mux_sel ? sext5(imm5) : m_regs[sr2]);
      clk_edge();
      chk_flags("rnd_nzp");
    end
    chk_all("rnd_end");

    // Async reset mid-operation with a pending R7 write.
    dr = 3'd7; bus = 16'hAAAA; ld_reg = 1'b1; ld_cc = 1'b1; clk_edge();
    ld_reg = 1'b0; ld_cc = 1'b0;
    sr1 = 3'd7; #1;
    chk("r7_pre", sr1_out, 16'hAAAA);
    @(posedge clk); #2;
    dr = 3'd7; bus = 16'h5555; ld_reg = 1'b1; ld_cc = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("r7_async_clr", sr1_out, 16'h0000);
    chk_flags("async_nzp");
    @(posedge clk); #1;
    chk("r7_held_in_reset", sr1_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("r7_before_first_edge", sr1_out, 16'h0000);
    clk_edge();
    chk("r7_first_load", sr1_out, 16'h5555);
    chk_flags("first_load_nzp");
    chk_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
